// File: rtl/br_fb_queue_pkg.sv
// Shared types and sizing for the branch-outcome feedback queue.
package br_fb_queue_pkg;

  // PC width of the fetch unit.
  localparam int unsigned AddrW = 32;

  // Queue depth shared by the fetch top level and the predictor instantiation.
  localparam int unsigned BrFbqDepth = 4;

  // One buffered committed-branch outcome.
  typedef struct packed {
    logic [AddrW-1:0] pc;
    logic             tk;
  } fb_entry_t;

endpackage

// File: rtl/fb_fifo_mem.sv
// Register array for the feedback queue: one write port, one asynchronous read port.
module fb_fifo_mem
  import br_fb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PtrW  = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [PtrW-1:0] waddr_i,
  input  fb_entry_t       wdata_i,
  input  logic [PtrW-1:0] raddr_i,
  output fb_entry_t       rdata_o
);

  fb_entry_t mem_q [DEPTH];

  // Storage is data-only; validity is tracked by the pointers in the parent.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/br_fb_queue.sv
// Buffers committed branch outcomes and releases one per predictor update window.
module br_fb_queue
  import br_fb_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = BrFbqDepth,
  parameter int unsigned DROP_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cm_br_valid_i,
  input  logic [AddrW-1:0]  cm_br_pc_i,
  input  logic              cm_br_tk_i,
  input  logic              pd_valid_i,
  output logic              fb_ena_o,
  output logic              fb_tk_o,
  output logic [AddrW-1:0]  fb_pc_o,
  output logic              fbq_empty_o,
  output logic              fbq_full_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic      empty, full, pop, push, ovf;
  fb_entry_t wr_entry, rd_entry;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CntW'(DEPTH));

  // Popping the head frees a slot, so a full queue still accepts a push that cycle.
  assign pop  = pd_valid_i && !empty;
  assign push = cm_br_valid_i && (!full || pop);
  assign ovf  = cm_br_valid_i && full && !pop;

  assign wr_entry.pc = cm_br_pc_i;
  assign wr_entry.tk = cm_br_tk_i;

  fb_fifo_mem #(
    .DEPTH (DEPTH),
    .PtrW  (PtrW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push && !rst_i),
    .waddr_i (tail_q),
    .wdata_i (wr_entry),
    .raddr_i (head_q),
    .rdata_o (rd_entry)
  );

  // Next-state for pointers, occupancy and the saturating drop counter.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    drop_d = drop_q;
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    if (push) begin
      tail_d = tail_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (ovf && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + 1'b1;
    end
  end

  // State registers with synchronous reset; inputs are ignored while reset is high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end

  // Outputs come only from registered state; head data is masked when empty.
  always_comb begin
    fb_ena_o    = !empty;
    fb_tk_o     = empty ? 1'b0 : rd_entry.tk;
    fb_pc_o     = empty ? '0 : rd_entry.pc;
    fbq_empty_o = empty;
    fbq_full_o  = full;
    drop_cnt_o  = drop_q;
  end

endmodule

// File: tb/tb_br_fb_queue.sv
// Directed bench for br_fb_queue with a queue-based reference model.
module tb_br_fb_queue;

  localparam int unsigned Depth = 4;
  localparam int unsigned DropW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cm_br_valid = 1'b0;
  logic [31:0] cm_br_pc = '0;
  logic        cm_br_tk = 1'b0;
  logic        pd_valid = 1'b0;
  logic        fb_ena, fb_tk, fbq_empty, fbq_full;
  logic [31:0] fb_pc;
  logic [DropW-1:0] drop_cnt;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: held entries as {pc, tk}, oldest first, plus a saturating drop count.
  logic [32:0] mq[$];
  int          m_drop = 0;

  always #5 clk = ~clk;

  br_fb_queue #(
    .DEPTH  (Depth),
    .DROP_W (DropW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cm_br_valid_i (cm_br_valid),
    .cm_br_pc_i    (cm_br_pc),
    .cm_br_tk_i    (cm_br_tk),
    .pd_valid_i    (pd_valid),
    .fb_ena_o      (fb_ena),
    .fb_tk_o       (fb_tk),
    .fb_pc_o       (fb_pc),
    .fbq_empty_o   (fbq_empty),
    .fbq_full_o    (fbq_full),
    .drop_cnt_o    (drop_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at the active edge, from the inputs the DUT samples there.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_drop = 0;
    end else begin
      bit popped;
      popped = pd_valid && (mq.size() > 0);
      if (cm_br_valid && !(mq.size() < Depth || popped)) begin
        if (m_drop < (1 << DropW) - 1) m_drop++;
      end
      if (popped) void'(mq.pop_front());
      if (cm_br_valid && (mq.size() < Depth)) mq.push_back({cm_br_pc, cm_br_tk});
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [32:0] hd;
      hd = (mq.size() > 0) ? mq[0] : 33'd0;
      check("fb_ena", 64'(fb_ena), 64'(mq.size() > 0));
      check("fb_pc", 64'(fb_pc), 64'(hd[32:1]));
      check("fb_tk", 64'(fb_tk), 64'(hd[0]));
      check("fbq_empty", 64'(fbq_empty), 64'(mq.size() == 0));
      check("fbq_full", 64'(fbq_full), 64'(mq.size() == Depth));
      check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    end
  end

  // Apply one cycle of stimulus; returns at the following falling edge.
  task automatic drive(input logic v, input logic [31:0] pc, input logic tk, input logic pdv,
                       input logic r = 1'b0);
    rst         = r;
    cm_br_valid = v;
    cm_br_pc    = pc;
    cm_br_tk    = tk;
    pd_valid    = pdv;
    @(negedge clk);
  endtask

  logic [31:0] in_seq[$];
  logic [31:0] out_seq[$];

  initial begin
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk_en = 1'b1;
    check("rst_empty", 64'(fbq_empty), 64'd1);
    check("rst_ena", 64'(fb_ena), 64'd0);
    check("rst_pc", 64'(fb_pc), 64'd0);

    // Basic pass-through.
    drive(1'b1, 32'h100, 1'b1, 1'b1);
    check("pt_ena", 64'(fb_ena), 64'd1);
    check("pt_pc", 64'(fb_pc), 64'h100);
    check("pt_tk", 64'(fb_tk), 64'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("pt_empty", 64'(fbq_empty), 64'd1);

    // Window gating: 10 closed cycles, head stays stable.
    for (int i = 0; i < 10; i++) begin
      if (i < 3) drive(1'b1, 32'h10 * (i + 1), i[0], 1'b0);
      else       drive(1'b0, 32'h0, 1'b0, 1'b0);
      check("gate_hold_pc", 64'(fb_pc), 64'h10);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("gate_drain1", 64'(fb_pc), 64'h20);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("gate_drain2", 64'(fb_pc), 64'h30);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("gate_drain3", 64'(fbq_empty), 64'd1);

    // Overflow: six pushes into four slots.
    for (int i = 0; i < 6; i++) drive(1'b1, 32'h40 + 32'(4 * i), 1'b1, 1'b0);
    check("ovf_full", 64'(fbq_full), 64'd1);
    check("ovf_drop", 64'(drop_cnt), 64'd2);
    for (int i = 0; i < 4; i++) begin
      check("ovf_order", 64'(fb_pc), 64'h40 + 64'(4 * i));
      drive(1'b0, 32'h0, 1'b0, 1'b1);
    end
    check("ovf_drained", 64'(fbq_empty), 64'd1);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    drive(1'b1, 32'h200, 1'b0, 1'b1);
    check("pp_full", 64'(fbq_full), 64'd1);
    check("pp_drop", 64'(drop_cnt), 64'd2);
    for (int i = 0; i < 3; i++) begin
      check("pp_order", 64'(fb_pc), 64'h301 + 64'(i));
      drive(1'b0, 32'h0, 1'b0, 1'b1);
    end
    check("pp_4th", 64'(fb_pc), 64'h200);
    drive(1'b0, 32'h0, 1'b0, 1'b1);

    // Saturation, then reset with three entries held.
    for (int i = 0; i < 9; i++) drive(1'b1, 32'h500 + 32'(i), 1'b1, 1'b0);
    check("sat_drop", 64'(drop_cnt), 64'd3);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 32'h777, 1'b1, 1'b1, 1'b1);
    check("rst_ena2", 64'(fb_ena), 64'd0);
    check("rst_pc2", 64'(fb_pc), 64'd0);
    check("rst_tk2", 64'(fb_tk), 64'd0);
    check("rst_empty2", 64'(fbq_empty), 64'd1);
    check("rst_drop2", 64'(drop_cnt), 64'd0);

    // Wrap-around stream with a pseudo-random update window, never overfilling.
    begin
      int pushed = 0;
      int cyc = 0;
      while ((pushed < 20 || !fbq_empty) && cyc < 400) begin
        logic v, pdv;
        logic [31:0] pc;
        pdv = 1'($urandom_range(0, 1));
        v   = (pushed < 20) && (mq.size() < Depth) && ($urandom_range(0, 3) != 0);
        pc  = 32'h1000 + 32'(pushed * 8);
        if (fb_ena && pdv) out_seq.push_back(fb_pc);
        if (v) begin
          in_seq.push_back(pc);
          pushed++;
        end
        drive(v, pc, pc[3], pdv);
        cyc++;
      end
      check("wrap_done", 64'(cyc < 400), 64'd1);
    end
    check("wrap_len", 64'(out_seq.size()), 64'd20);
    for (int i = 0; i < 20; i++) begin
      if (i < out_seq.size()) check("wrap_seq", 64'(out_seq[i]), 64'h1000 + 64'(i * 8));
    end
    check("wrap_drop", 64'(drop_cnt), 64'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/br_fb_queue.md
# br_fb_queue

Buffers committed conditional-branch outcomes and feeds them, one per cycle, into the branch predictor's feedback port (`fb_ena`/`fb_tk`/`fb_pc`). The predictor only applies feedback in cycles where `pd_valid` is high, so outcomes arriving in other cycles would be lost. This block holds them in a small FIFO and releases each one exactly in an accepting cycle. It sits between the ROB commit stage and the predictor, in the fetch unit.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `DROP_W`, 8: width of the dropped-outcome counter.

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `cm_br_valid`  in  1  a conditional branch (opcode 'h63) committed this cycle
- `cm_br_pc`  in  `ADDR_TP`  PC of the committed branch
- `cm_br_tk`  in  1  resolved direction; 1 = taken
- `pd_valid`  in  1  predictor update window; the same net that drives the predictor's `pd_valid`
- `fb_ena`  out  1  head entry presented to the predictor
- `fb_tk`  out  1  direction of the head entry
- `fb_pc`  out  `ADDR_TP`  PC of the head entry
- `fbq_empty`  out  1  no entries held
- `fbq_full`  out  1  `DEPTH` entries held
- `drop_cnt`  out  `DROP_W`  saturating count of outcomes discarded on overflow

## Operation
- Storage is a circular buffer of {pc, tk}, with head pointer, tail pointer and occupancy count.
  - Pointer width is log2(DEPTH); pointers wrap modulo DEPTH.
  - Count width is log2(DEPTH)+1.
- Outputs:
  - `fb_ena` = !`fbq_empty`.
  - `fb_tk`/`fb_pc` = head entry when not empty, else 0.
  - All outputs are decoded from registered state. There is no combinational path from any input to any output.
- Pop: occurs when `pd_valid` && !`fbq_empty`. The head pointer advances at the clock edge. The predictor consumes the head in that same cycle.
- Push: occurs when `cm_br_valid` && (!`fbq_full` || pop). The entry is written at the tail and the tail advances.
- Push and pop in the same cycle:
  - Both pointers advance and the count is unchanged.
  - This is legal when full; the incoming entry is accepted.
- Overflow: `cm_br_valid` && `fbq_full` && no pop.
  - The incoming outcome is discarded and the FIFO is unchanged.
  - `drop_cnt` increments and saturates at all-ones.
  - Commit is never stalled; predictor training is non-architectural.
- No bypass: an outcome pushed at edge N is presentable from cycle N+1 at the earliest.
- There is no flush input. Committed outcomes are architectural history and survive pipeline flushes.
- Order is strict FIFO. No coalescing of entries that hash to the same BHT index.

## Timing
- Reset (synchronous, `rst` sampled high at an edge):
  - head, tail and count go to 0; `drop_cnt` goes to 0.
  - In the following cycle: `fb_ena`=0, `fb_tk`=0, `fb_pc`=0, `fbq_empty`=1, `fbq_full`=0.
  - Reset mid-operation discards all held entries; no partial pop is emitted.
  - Inputs are ignored in any cycle where `rst`=1.
- Latency from push to earliest feedback is 1 cycle, given `pd_valid` high. Otherwise the entry waits indefinitely.
- Throughput is 1 push and 1 pop per cycle.
- `fbq_full`/`fbq_empty` reflect the registered count only; there is no look-ahead.

## Structure
- `ADDR_TP`, `TRUE`, `FALSE` come from the shared `utils.v`.
- Add `BR_FBQ_DEPTH` to `utils.v` so the fetch top-level and the predictor instantiation agree on it.
- One natural sub-module, `fb_fifo_mem`: the DEPTH×(ADDR+1) register array with one write port and one asynchronous read port.
- The control logic (pointers, count, drop counter) stays in `br_fb_queue`.

## Test plan
- Basic pass-through:
  - Stimulus: reset; push {pc='h100, tk=1} with `pd_valid`=1 held.
  - Required: `fb_ena`=1 with `fb_pc`='h100 and `fb_tk`=1 in the next cycle only; then `fbq_empty`=1.
- Window gating:
  - Stimulus: push 3 outcomes with `pd_valid`=0 for 10 cycles, then raise `pd_valid`.
  - Required: `fb_ena` stays 1 with the first entry held stable for all 10 cycles; the entries then drain in order over 3 consecutive cycles.
- Overflow:
  - Stimulus: with DEPTH=4 and `pd_valid`=0, push 6 outcomes.
  - Required: `fbq_full`=1, `drop_cnt`=2, and the first 4 PCs drain later in order.
- Full with simultaneous push and pop:
  - Stimulus: fill to 4, then push 'h200 with `pd_valid`=1.
  - Required: `drop_cnt` unchanged, count stays 4, and 'h200 emerges 4th in drain order.
- Saturation and reset:
  - Stimulus: with DROP_W=2, force 5 drops, then assert `rst` while 3 entries are held.
  - Required: `drop_cnt`=3 before reset; one cycle after reset all outputs are 0 and `fbq_empty`=1.
- Wrap-around:
  - Stimulus: stream 20 outcomes with `pd_valid` toggling pseudo-randomly.
  - Required: the output sequence matches the input sequence exactly, with no loss while never full.
